pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-sequencing controller for the 5-stage (F/D/X/M/W) TinyRV1 processor, sitting in the control unit between the decode logic and the datapath.
- Tracks valid/rd/wen/load state for X, M and W.
- Generates operand bypass selects, load-use stalls and squashes for taken branches and jumps.
- Adds what the previous control had no support for: a multi-cycle multiplier occupying X for MUL_LAT cycles, plus a compile-time choice between full bypassing and stall-only interlock.

---
 rtl/pipe_ctrl_pkg.sv | 47 ++++
 rtl/pipe_mul_timer.sv | 56 +++++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the TinyRV1 hazard controller.
//   byp_sel_t    : operand source select (RF / X / M / W).
//   stage_info_t : per-stage tracking record (val, rd, wen, is_load).
//   MUL_LAT_MAX  : largest supported multiplier latency.
// The rd field is sized for RA_W_MAX. Narrower register addresses are
// zero-extended into it, so RA_W must not exceed RA_W_MAX.
package pipe_ctrl_pkg;

    localparam int MUL_LAT_MAX = 16;
    localparam int RA_W_MAX    = 8;

    typedef enum logic [1:0] {
        BYP_RF = 2'd0,
        BYP_X  = 2'd1,
        BYP_M  = 2'd2,
        BYP_W  = 2'd3
    } byp_sel_t;

    typedef struct packed {
        logic                val;
        logic [RA_W_MAX-1:0] rd;
        logic                wen;
        logic                is_load;
    } stage_info_t;

    // True when stage s will write register src, src is a real read of a
    // nonzero register, and s holds a live instruction.
    function automatic logic raw_hit(input stage_info_t s,
                                     input logic [RA_W_MAX-1:0] src,
                                     input logic en);
        return en && (src != '0) && s.val && s.wen && (s.rd == src);
    endfunction

    // Youngest producer wins. A load in X has no data yet, so X is skipped
    // for loads; the load-use stall covers that case.
    function automatic byp_sel_t byp_pick(input logic [RA_W_MAX-1:0] src,
                                          input logic en,
                                          input stage_info_t x,
                                          input stage_info_t m,
                                          input stage_info_t w);
        if (raw_hit(x, src, en) && !x.is_load) return BYP_X;
        if (raw_hit(m, src, en))               return BYP_M;
        if (raw_hit(w, src, en))               return BYP_W;
        return BYP_RF;
    endfunction

endpackage

// File: rtl/pipe_mul_timer.sv
// pipe_mul_timer: counts the extra cycles a MUL spends in X.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low
//   start : a valid MUL is advancing D->X this cycle
//   busy  : MUL iterating in X (X must hold, D must stall)
// MUL_LAT = 1 never leaves IDLE.
module pipe_mul_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam int CW = $clog2(MUL_LAT) + 1;

    typedef enum logic {IDLE, BUSY} mstate_t;

    mstate_t        state_q, state_d;
    logic [CW-1:0]  mcnt_q, mcnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (MUL_LAT > 1)) begin
                    mcnt_d  = CW'(MUL_LAT - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy   = 1'b1;
                mcnt_d = mcnt_q - 1'b1;
                // Last busy cycle: the following cycle is the MUL's final one in X.
                if (mcnt_q == CW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard / sequencing control for the 5-stage TinyRV1 pipe.
// Inputs : D-stage decode info (d_*), x_br_taken from the X branch unit.
// Outputs: fetch/decode enables, X hold, operand bypass selects, squashes,
//          X/M/W valid bits, register-file write port control, mul_busy.
// Build option PIPE_HAZARD_BYPASS_EN: defined -> full bypassing from X/M/W;
// undefined -> bypass selects tied to RF and every RAW against a live
// writer in X, M or W stalls D (the RF is not write-through).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W    = 5,
    parameter int MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            d_val,
    input  logic [RA_W-1:0] d_rs1,
    input  logic            d_rs1_en,
    input  logic [RA_W-1:0] d_rs2,
    input  logic            d_rs2_en,
    input  logic [RA_W-1:0] d_rd,
    input  logic            d_wen,
    input  logic            d_is_load,
    input  logic            d_is_mul,
    input  logic            d_is_jump,
    input  logic            x_br_taken,
    output logic            reg_en_F,
    output logic            reg_en_D,
    output logic            x_hold,
    output logic [1:0]      op1_byp_sel,
    output logic [1:0]      op2_byp_sel,
    output logic            squash_F,
    output logic            squash_D,
    output logic            val_X,
    output logic            val_M,
    output logic            val_W,
    output logic            rf_wen_W,
    output logic [RA_W-1:0] rf_waddr_W,
    output logic            mul_busy
);

    stage_info_t x_q, m_q, w_q;
    stage_info_t x_d, m_d, w_d;

    logic [RA_W_MAX-1:0] rs1, rs2, rd_in;
    logic load_use, raw_stall, stall_D, mul_start;

    assign rs1   = RA_W_MAX'(d_rs1);
    assign rs2   = RA_W_MAX'(d_rs2);
    assign rd_in = RA_W_MAX'(d_rd);

    pipe_mul_timer #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .busy  (mul_busy)
    );

    assign x_hold = mul_busy;

    // Load data only exists from M onward, so a dependent in D waits one cycle.
    assign load_use = x_q.is_load &&
                      (raw_hit(x_q, rs1, d_rs1_en) || raw_hit(x_q, rs2, d_rs2_en));

`ifdef PIPE_HAZARD_BYPASS_EN
    assign raw_stall   = 1'b0;
    assign op1_byp_sel = byp_pick(rs1, d_rs1_en, x_q, m_q, w_q);
    assign op2_byp_sel = byp_pick(rs2, d_rs2_en, x_q, m_q, w_q);
`else
    assign raw_stall   = raw_hit(x_q, rs1, d_rs1_en) || raw_hit(x_q, rs2, d_rs2_en) ||
                         raw_hit(m_q, rs1, d_rs1_en) || raw_hit(m_q, rs2, d_rs2_en) ||
                         raw_hit(w_q, rs1, d_rs1_en) || raw_hit(w_q, rs2, d_rs2_en);
    assign op1_byp_sel = BYP_RF;
    assign op2_byp_sel = BYP_RF;
`endif

    assign stall_D  = d_val && (load_use || mul_busy || raw_stall);
    assign squash_D = x_q.val && x_br_taken;
    assign squash_F = squash_D || (d_val && d_is_jump && !stall_D);
    // A squashed D is dead, so the front end must move even if D would stall.
    assign reg_en_F = !stall_D || squash_D;
    assign reg_en_D = reg_en_F;

    assign mul_start = d_val && d_is_mul && !stall_D && !squash_D;

    always_comb begin
        x_d = '0;
        if (mul_busy)
            x_d = x_q;
        else if (!(stall_D || squash_D))
            x_d = '{val: d_val, rd: rd_in, wen: d_wen, is_load: d_is_load};
        m_d = mul_busy ? '0 : x_q;
        w_d = m_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            x_q <= x_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign val_X      = x_q.val;
    assign val_M      = m_q.val;
    assign val_W      = w_q.val;
    assign rf_wen_W   = w_q.val && w_q.wen && (w_q.rd != '0);
    assign rf_waddr_W = w_q.rd[RA_W-1:0];

    // Load flags past X carry no control meaning; kept for debug visibility.
    logic unused_bits;
    assign unused_bits = m_q.is_load ^ w_q.is_load;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (RA_W=5, MUL_LAT=4). Covers both
// builds; bypass-specific expectations follow PIPE_HAZARD_BYPASS_EN.
module tb_pipe_hazard_ctrl;
    localparam int RA_W    = 5;
    localparam int MUL_LAT = 4;

    logic clk, rst;
    logic d_val, d_rs1_en, d_rs2_en, d_wen, d_is_load, d_is_mul, d_is_jump, x_br_taken;
    logic [RA_W-1:0] d_rs1, d_rs2, d_rd;
    logic reg_en_F, reg_en_D, x_hold, squash_F, squash_D;
    logic val_X, val_M, val_W, rf_wen_W, mul_busy;
    logic [1:0] op1_byp_sel, op2_byp_sel;
    logic [RA_W-1:0] rf_waddr_W;

    int n_chk = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(.RA_W(RA_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .d_val(d_val), .d_rs1(d_rs1), .d_rs1_en(d_rs1_en),
        .d_rs2(d_rs2), .d_rs2_en(d_rs2_en), .d_rd(d_rd), .d_wen(d_wen),
        .d_is_load(d_is_load), .d_is_mul(d_is_mul), .d_is_jump(d_is_jump),
        .x_br_taken(x_br_taken),
        .reg_en_F(reg_en_F), .reg_en_D(reg_en_D), .x_hold(x_hold),
        .op1_byp_sel(op1_byp_sel), .op2_byp_sel(op2_byp_sel),
        .squash_F(squash_F), .squash_D(squash_D),
        .val_X(val_X), .val_M(val_M), .val_W(val_W),
        .rf_wen_W(rf_wen_W), .rf_waddr_W(rf_waddr_W), .mul_busy(mul_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic dset(input logic v, input logic [4:0] r1, input logic e1,
                        input logic [4:0] r2, input logic e2, input logic [4:0] rd,
                        input logic w, input logic ld, input logic mul, input logic jmp);
        d_val = v; d_rs1 = r1; d_rs1_en = e1; d_rs2 = r2; d_rs2_en = e2;
        d_rd = rd; d_wen = w; d_is_load = ld; d_is_mul = mul; d_is_jump = jmp;
        #1;
    endtask

    task automatic nop();
        dset(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock; inputs change and checks happen mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (4) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; x_br_taken = 1'b0;
        nop();
        #1 rst = 1'b0;
        #1;
        chk("rst_en_F",   reg_en_F, 1);
        chk("rst_en_D",   reg_en_D, 1);
        chk("rst_hold",   x_hold, 0);
        chk("rst_sqF",    squash_F, 0);
        chk("rst_sqD",    squash_D, 0);
        chk("rst_byp1",   op1_byp_sel, 0);
        chk("rst_byp2",   op2_byp_sel, 0);
        chk("rst_vals",   {val_X, val_M, val_W}, 0);
        chk("rst_rfwen",  rf_wen_W, 0);
        chk("rst_busy",   mul_busy, 0);
        repeat (2) step();
        rst = 1'b1;
        step();

        // ---- RAW: ADD x4 then ADD rs1=4 ----
        dset(1, 1, 1, 2, 1, 4, 1, 0, 0, 0);
        chk("raw_c0_en", reg_en_F, 1);
        step();
        dset(1, 4, 1, 0, 0, 11, 1, 0, 0, 0);
`ifdef PIPE_HAZARD_BYPASS_EN
        chk("raw_c1_en",   reg_en_F, 1);
        chk("raw_c1_byp1", op1_byp_sel, 1);
        step(); nop();
        chk("raw_adv_valX", val_X, 1);
`else
        chk("raw_c1_en",   reg_en_F, 0);
        chk("raw_c1_byp1", op1_byp_sel, 0);
        step();
        chk("raw_c2_en",   reg_en_F, 0);
        chk("raw_c2_valX", val_X, 0);
        chk("raw_c2_valM", val_M, 1);
        step();
        chk("raw_c3_en",   reg_en_D, 0);
        chk("raw_c3_rfw",  rf_wen_W, 1);
        chk("raw_c3_addr", rf_waddr_W, 4);
        step();
        chk("raw_c4_en",   reg_en_F, 1);
        step(); nop();
        chk("raw_adv_valX", val_X, 1);
`endif
        drain();

        // ---- rd=0 writer: no dependence, no RF write ----
        dset(1, 1, 1, 2, 1, 0, 1, 0, 0, 0);
        step();
        dset(1, 0, 0, 0, 1, 12, 1, 0, 0, 0);
        chk("rd0_en",   reg_en_F, 1);
        chk("rd0_byp2", op2_byp_sel, 0);
        step(); nop();
        step();
        chk("rd0_valW", val_W, 1);
        chk("rd0_rfw",  rf_wen_W, 0);
        drain();
`ifdef PIPE_HAZARD_BYPASS_EN
        dset(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        step();
        dset(1, 0, 0, 3, 1, 13, 1, 0, 0, 0);
        chk("bx_byp2", op2_byp_sel, 1);
        chk("bx_en",   reg_en_F, 1);
        drain();
`endif

        // ---- load-use: LW x5 then JR x5 ----
        dset(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
        step();
        dset(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("lu_c1_en",  reg_en_F, 0);
        chk("lu_c1_sqF", squash_F, 0);
        chk("lu_c1_sqD", squash_D, 0);
        step();
        chk("lu_c2_valX", val_X, 0);
`ifdef PIPE_HAZARD_BYPASS_EN
        chk("lu_c2_en",   reg_en_F, 1);
        chk("lu_c2_byp1", op1_byp_sel, 2);
        chk("lu_c2_sqF",  squash_F, 1);
`else
        chk("lu_c2_en",   reg_en_F, 0);
        repeat (2) step();
        chk("lu_c4_en",   reg_en_F, 1);
        chk("lu_c4_sqF",  squash_F, 1);
`endif
        drain();

        // ---- MUL occupying X for 4 cycles ----
        dset(1, 1, 1, 2, 1, 6, 1, 0, 1, 0);
        step();
        dset(1, 8, 1, 9, 1, 7, 1, 0, 0, 0);
        chk("mul_c1_busy", mul_busy, 1);
        chk("mul_c1_hold", x_hold, 1);
        chk("mul_c1_en",   reg_en_F, 0);
        chk("mul_c1_valX", val_X, 1);
        step();
        chk("mul_c2_busy", mul_busy, 1);
        chk("mul_c2_valM", val_M, 0);
        step();
        chk("mul_c3_busy", mul_busy, 1);
        chk("mul_c3_valM", val_M, 0);
        step();
        chk("mul_c4_busy", mul_busy, 0);
        chk("mul_c4_hold", x_hold, 0);
        chk("mul_c4_en",   reg_en_F, 1);
        chk("mul_c4_valM", val_M, 0);
        step(); nop();
        chk("mul_c5_vals", {val_X, val_M}, 2'b11);
        step();
        chk("mul_c6_rfw",  rf_wen_W, 1);
        chk("mul_c6_addr", rf_waddr_W, 6);
        drain();

        // ---- taken BNE in X with JAL in D ----
        dset(1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
        step();
        x_br_taken = 1'b1;
        dset(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        chk("bj_sqF", squash_F, 1);
        chk("bj_sqD", squash_D, 1);
        chk("bj_en",  reg_en_F, 1);
        step();
        x_br_taken = 1'b0;
        nop();
        chk("bj_valX", val_X, 0);
        chk("bj_valM", val_M, 1);
        step();
        chk("bj_rfw_a", rf_wen_W, 0);
        step();
        chk("bj_rfw_b", {val_W, rf_wen_W}, 0);
        drain();
        // branch flag with empty X is ignored; lone jump squashes F only
        x_br_taken = 1'b1;
        #1;
        chk("br_noval_sqD", squash_D, 0);
        x_br_taken = 1'b0;
        dset(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        chk("jmp_sqF", squash_F, 1);
        chk("jmp_sqD", squash_D, 0);
        drain();

        // ---- async reset mid-MUL ----
        dset(1, 1, 1, 2, 1, 9, 1, 0, 0, 0);
        step();
        dset(1, 3, 1, 4, 1, 10, 1, 0, 1, 0);
        step(); nop();
        step();
        chk("rm_pre_rfw",  rf_wen_W, 1);
        chk("rm_pre_busy", mul_busy, 1);
        rst = 1'b0;
        #1;
        chk("rm_busy", mul_busy, 0);
        chk("rm_hold", x_hold, 0);
        chk("rm_vals", {val_X, val_M, val_W}, 0);
        chk("rm_rfw",  rf_wen_W, 0);
        chk("rm_en",   reg_en_F, 1);
        step();
        rst = 1'b1;
        step();
        chk("rm_post_busy", mul_busy, 0);
        chk("rm_post_valX", val_X, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
